// File: rtl/mem_write_monitor.sv
// mem_write_monitor: watches the CPU data-memory write bus and latches a sticky
// PASS / FAIL / TIMEOUT verdict with run counters and offending-store capture.
module mem_write_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd84,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd80,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      dataadr,
  input  logic [31:0]      writedata,
  output logic [2:0]       state,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] write_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [31:0]      fail_adr,
  output logic [31:0]      fail_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_PASS    = 3'd2;
  localparam logic [2:0] S_FAIL    = 3'd3;
  localparam logic [2:0] S_TIMEOUT = 3'd4;

  // Value of cycle_count on the last RUN edge before the timeout fires.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] ccnt_q, ccnt_d;
  logic [31:0]      fadr_q, fadr_d;
  logic [31:0]      fdat_q, fdat_d;

  logic is_pass_store, is_fail_store;

  assign is_pass_store = memwrite && (dataadr == PASS_ADDR) && (writedata == PASS_DATA);
  assign is_fail_store = memwrite && !is_pass_store && (dataadr != SCRATCH_ADDR);

  // State, counter and capture registers; reset clears everything from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      ccnt_q  <= '0;
      fadr_q  <= '0;
      fdat_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ccnt_q  <= ccnt_d;
      fadr_q  <= fadr_d;
      fdat_q  <= fdat_d;
    end
  end

  // Next state and datapath: only RUN edges count, classify and capture;
  // a terminating store beats a timeout landing on the same edge.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ccnt_d  = ccnt_q;
    fadr_d  = fadr_q;
    fdat_d  = fdat_q;
    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        if (ccnt_q != '1) ccnt_d = ccnt_q + 1'b1;
        if (memwrite && (wcnt_q != '1)) wcnt_d = wcnt_q + 1'b1;
        if (is_pass_store) begin
          state_d = S_PASS;
        end else if (is_fail_store) begin
          state_d = S_FAIL;
          fadr_d  = dataadr;
          fdat_d  = writedata;
        end else if (ccnt_q == TO_LAST) begin
          state_d = S_TIMEOUT;
        end
      end
      S_PASS, S_FAIL, S_TIMEOUT: state_d = state_q;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    state       = state_q;
    done        = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TIMEOUT);
    pass        = (state_q == S_PASS);
    fail        = (state_q == S_FAIL) || (state_q == S_TIMEOUT);
    write_count = wcnt_q;
    cycle_count = ccnt_q;
    fail_adr    = fadr_q;
    fail_data   = fdat_q;
  end

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed bench for mem_write_monitor with a transaction-level reference model
// compared on every cycle, plus literal spot checks on key moments.
module tb_mem_write_monitor;

  localparam int TO    = 10;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             memwrite;
  logic [31:0]      dataadr;
  logic [31:0]      writedata;
  logic [2:0]       state;
  logic             done, pass, fail;
  logic [CNT_W-1:0] write_count, cycle_count;
  logic [31:0]      fail_adr, fail_data;

  int nvec = 0;
  int nerr = 0;

  mem_write_monitor #(
    .PASS_ADDR(32'd84), .PASS_DATA(32'd7), .SCRATCH_ADDR(32'd80),
    .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .state(state), .done(done), .pass(pass),
    .fail(fail), .write_count(write_count), .cycle_count(cycle_count),
    .fail_adr(fail_adr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  // Reference model: verdict string-level phases, plain integer run/store tallies.
  int  m_phase;     // 0 idle, 1 running, 2 pass, 3 fail, 4 timeout
  int  m_runs, m_writes;
  int  m_fadr, m_fdat;
  bit  started = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_runs = 0; m_writes = 0; m_fadr = 0; m_fdat = 0;
      started = 1;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_runs++;
      if (memwrite) m_writes++;
      if (memwrite && dataadr == 84 && writedata == 7) m_phase = 2;
      else if (memwrite && dataadr != 80) begin
        m_phase = 3; m_fadr = dataadr; m_fdat = writedata;
      end else if (m_runs == TO) m_phase = 4;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("state", state, m_phase);
      chk("done", done, m_phase >= 2);
      chk("pass", pass, m_phase == 2);
      chk("fail", fail, m_phase == 3 || m_phase == 4);
      chk("write_count", write_count, (m_writes > CMAX) ? CMAX : m_writes);
      chk("cycle_count", cycle_count, (m_runs > CMAX) ? CMAX : m_runs);
      chk("fail_adr", fail_adr, m_fadr);
      chk("fail_data", fail_data, m_fdat);
    end
  end

  // One clock edge with the given inputs; returns at the following negedge.
  task automatic step(input bit r, input bit mw, input int a, input int d);
    reset = r; memwrite = mw; dataadr = a; writedata = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; memwrite = 0; dataadr = 0; writedata = 0;
    @(negedge clk);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_state", state, 0);
    chk("rst_cc", cycle_count, 0);
    chk("rst_done", done, 0);

    // IDLE ignores a valid-looking pass store, then RUN counts
    step(0, 1, 84, 7);
    chk("idle_to_run", state, 1);
    chk("idle_wc", write_count, 0);
    idle(2);
    chk("run_cc", cycle_count, 2);

    // scratch, scratch, pass
    step(0, 1, 80, 5);
    step(0, 1, 80, 6);
    chk("scratch_state", state, 1);
    step(0, 1, 84, 7);
    chk("pass_state", state, 2);
    chk("pass_wc", write_count, 3);
    chk("pass_pass", pass, 1);
    chk("pass_fail", fail, 0);
    step(0, 1, 88, 1);
    idle(2);
    chk("pass_sticky", state, 2);
    chk("pass_frozen_cc", cycle_count, 5);

    // scratch then bad address, later pass stores ignored
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 80, 1);
    step(0, 1, 88, 7);
    chk("fail_state", state, 3);
    chk("fail_adr", fail_adr, 88);
    chk("fail_data", fail_data, 7);
    chk("fail_wc", write_count, 2);
    step(0, 1, 84, 7);
    step(0, 1, 84, 7);
    chk("fail_sticky", state, 3);
    chk("fail_wc_frozen", write_count, 2);

    // right address, wrong data
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 84, 6);
    chk("wrongdata_state", state, 3);
    chk("wrongdata_adr", fail_adr, 84);
    chk("wrongdata_data", fail_data, 6);

    // timeout with idle bus
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    idle(TO - 1);
    chk("pre_to_state", state, 1);
    idle(1);
    chk("to_state", state, 4);
    chk("to_cc", cycle_count, 10);
    chk("to_fail", fail, 1);
    chk("to_adr", fail_adr, 0);

    // pass store on the expiry edge wins
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    idle(TO - 1);
    step(0, 1, 84, 7);
    chk("edge_pass_state", state, 2);
    chk("edge_pass_cc", cycle_count, 10);

    // scratch store on the expiry edge does not prevent timeout
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    idle(TO - 1);
    step(0, 1, 80, 3);
    chk("edge_scratch_state", state, 4);
    chk("edge_scratch_wc", write_count, 1);

    // reset mid-run, fresh run, reset in PASS
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 80, 9);
    idle(2);
    step(1, 0, 0, 0);
    chk("midrst_state", state, 0);
    chk("midrst_wc", write_count, 0);
    chk("midrst_cc", cycle_count, 0);
    step(0, 0, 0, 0);
    step(0, 1, 84, 7);
    chk("fresh_pass", state, 2);
    chk("fresh_cc", cycle_count, 1);
    step(1, 0, 0, 0);
    chk("passrst_state", state, 0);
    chk("passrst_wc", write_count, 0);
    chk("passrst_done", done, 0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_write_monitor.md
Name: mem_write_monitor

Overview:
- Synthesizable result checker sitting directly downstream of the pipelined CPU top level, on its data-memory write bus (memwrite, dataadr, writedata).
- Classifies every store as scratch, pass or fail; also detects a run timeout.
- Latches a sticky verdict plus debug capture, so FPGA builds report pass/fail on LEDs or a register without a simulator.

Parameters:
- PASS_ADDR, 32'd84, store address that signals success.
- PASS_DATA, 32'd7, data required at PASS_ADDR for success.
- SCRATCH_ADDR, 32'd80, address where stores are tolerated and ignored.
- TIMEOUT_CYCLES, 1000, RUN cycles allowed before TIMEOUT; must be >= 2.
- CNT_W, 16, width of the cycle and write counters.

Ports:
- clk  in  1  rising-edge clock, same clock as the CPU.
- reset  in  1  synchronous, active-high reset.
- memwrite  in  1  CPU data-memory write enable.
- dataadr  in  32  CPU data-memory byte address.
- writedata  in  32  CPU store data.
- state  out  3  IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4.
- done  out  1  high in PASS, FAIL or TIMEOUT.
- pass  out  1  high only in PASS.
- fail  out  1  high in FAIL or TIMEOUT.
- write_count  out  CNT_W  stores observed in RUN.
- cycle_count  out  CNT_W  cycles spent in RUN.
- fail_adr  out  32  dataadr of the offending store.
- fail_data  out  32  writedata of the offending store.

Behaviour:
- All outputs are registered or decoded from the registered state. No combinational path from inputs to outputs.
- Reset (sampled at posedge, reset=1):
  - state=IDLE.
  - write_count, cycle_count, fail_adr and fail_data all 0.
  - done, pass and fail are 0.
  - Reset asserted in any state, including mid-run or terminal, returns to IDLE on that edge.
- IDLE: the first edge with reset=0 moves to RUN. Inputs are ignored in IDLE, including memwrite.
- RUN: each edge, evaluate in this priority order:
  - memwrite=1 and dataadr==PASS_ADDR and writedata==PASS_DATA -> PASS.
  - memwrite=1 and dataadr!=SCRATCH_ADDR -> FAIL. Capture fail_adr=dataadr and fail_data=writedata. This includes PASS_ADDR with wrong data.
  - memwrite=1 and dataadr==SCRATCH_ADDR -> stay in RUN.
  - No qualifying store and cycle_count==TIMEOUT_CYCLES-1 -> TIMEOUT. fail_adr and fail_data stay 0.
  - Otherwise stay in RUN.
- Store versus timeout: a terminating store on the same edge as timeout expiry wins (PASS or FAIL, not TIMEOUT). A scratch store on the expiry edge does not prevent TIMEOUT.
- Counters (RUN edges only):
  - cycle_count increments on every RUN edge, including the edge that leaves RUN.
  - write_count increments on every edge with memwrite=1, including the terminating store.
  - Both saturate at all-ones and never wrap.
- Latency: the verdict is visible one cycle after the store's edge. A store on edge N gives state/pass/fail after edge N.
- PASS, FAIL and TIMEOUT are sticky until reset. Counters and capture registers freeze, and further memwrite activity is ignored.
- Full 32-bit equality compares; no byte masking.
- Inputs carrying X/Z are not handled specially. The bench holds inputs known after reset.

Test Plan:
- Reset then idle bus → IDLE for 1 cycle after reset deasserts, then RUN; cycle_count counts; done=0.
- Stores (80,5), (80,6), (84,7) on consecutive cycles → RUN, RUN, then PASS one cycle after the third store; write_count=3; pass=1, fail=0.
- Store (80,1) then (88,7) → FAIL; fail_adr=88, fail_data=7, write_count=2. Later stores of (84,7) leave state FAIL.
- Store (84,6) → FAIL; fail_adr=84, fail_data=6 (right address, wrong data).
- TIMEOUT_CYCLES=10, no stores → TIMEOUT after the 10th RUN edge; cycle_count=10; fail=1; fail_adr=0.
- TIMEOUT_CYCLES=10, with (84,7) on the 10th RUN edge → PASS, not TIMEOUT.
- Repeat with (80,3) on the 10th RUN edge → TIMEOUT.
- Reset pulsed mid-RUN, and again in PASS → IDLE with all counters and captures 0, then a fresh run.
